// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - sizing functions and state encoding shared by the MLP sequencer
package mlp_pkg;

  typedef enum logic [2:0] {IDLE, L1, L2, DRAIN, DONE} state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int l2_base_f(input int input_num, input int neuron_num);
    return neuron_num * (input_num + 1);
  endfunction

  function automatic int depth_f(input int input_num, input int neuron_num, input int output_num);
    return l2_base_f(input_num, neuron_num) + output_num * (neuron_num + 1);
  endfunction

  function automatic int idx_w_f(input int input_num, input int neuron_num, input int output_num);
    return clog2_min1(max2(max2(input_num, neuron_num), output_num));
  endfunction

  // Term counter must reach fan-in itself (the bias slot), hence the +1.
  function automatic int term_w_f(input int input_num, input int neuron_num);
    return clog2_min1(max2(input_num, neuron_num) + 1);
  endfunction

endpackage

// File: rtl/mlp_term_cnt.sv
// rtl/mlp_term_cnt.sv - nested term/neuron counter with programmable fan-in and neuron count
module mlp_term_cnt #(
  parameter int TERM_W = 4,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              arstb,
  input  logic              clr,
  input  logic              adv,
  input  logic [TERM_W-1:0] fan_in,
  input  logic [IDX_W-1:0]  last_idx,
  output logic [TERM_W-1:0] term,
  output logic [IDX_W-1:0]  idx,
  output logic              first,
  output logic              last_term,
  output logic              last_all
);

  assign first     = (term == '0);
  assign last_term = (term == fan_in);
  assign last_all  = last_term && (idx == last_idx);

  // Wrapping on last_all leaves the counter at (0,0), ready for the next layer.
  always_ff @(posedge clk) begin
    if (!arstb || clr) begin
      term <= '0;
      idx  <= '0;
    end else if (adv) begin
      if (last_term) begin
        term <= '0;
        idx  <= last_all ? '0 : idx + 1'b1;
      end else begin
        term <= term + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mlp_seq_ctrl.sv
// rtl/mlp_seq_ctrl.sv - MLP inference sequencer and weight-memory port arbiter
module mlp_seq_ctrl
  import mlp_pkg::*;
#(
  parameter int   INPUT_NUM  = 5,
  parameter int   NEURON_NUM = 8,
  parameter int   OUTPUT_NUM = 4,
  localparam int  L2_BASE    = l2_base_f(INPUT_NUM, NEURON_NUM),
  localparam int  DEPTH      = depth_f(INPUT_NUM, NEURON_NUM, OUTPUT_NUM),
  localparam int  ADDR_W     = clog2_min1(DEPTH),
  localparam int  IDX_W      = idx_w_f(INPUT_NUM, NEURON_NUM, OUTPUT_NUM)
) (
  input  logic              clk,
  input  logic              arstb,
  input  logic              start,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ready,
  output logic              wr_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              src_sel,
  output logic [IDX_W-1:0]  src_idx,
  output logic              bias_term,
  output logic              res_we,
  output logic              res_layer,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy,
  output logic              done
);

  localparam int TERM_W = term_w_f(INPUT_NUM, NEURON_NUM);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_t              state;
  logic                start_pend;
  logic                drain_cnt;
  logic                issuing;
  logic                in_l2;
  logic                wr_ok;
  logic [TERM_W-1:0]   fan_in;
  logic [IDX_W-1:0]    last_idx;
  logic [TERM_W-1:0]   term;
  logic [IDX_W-1:0]    nidx;
  logic                first;
  logic                last_term;
  logic                last_all;
  logic [ADDR_W-1:0]   issue_addr;
  logic                d1_last;
  logic                d1_layer;
  logic [IDX_W-1:0]    d1_idx;

  assign issuing  = (state == L1) || (state == L2);
  assign in_l2    = (state == L2);
  assign fan_in   = in_l2 ? TERM_W'(NEURON_NUM) : TERM_W'(INPUT_NUM);
  assign last_idx = in_l2 ? IDX_W'(OUTPUT_NUM - 1) : IDX_W'(NEURON_NUM - 1);

  mlp_term_cnt #(
    .TERM_W (TERM_W),
    .IDX_W  (IDX_W)
  ) u_term_cnt (
    .clk       (clk),
    .arstb     (arstb),
    .clr       (!issuing),
    .adv       (issuing),
    .fan_in    (fan_in),
    .last_idx  (last_idx),
    .term      (term),
    .idx       (nidx),
    .first     (first),
    .last_term (last_term),
    .last_all  (last_all)
  );

  assign issue_addr = in_l2
    ? ADDR_W'(L2_BASE) + ADDR_W'(nidx) * ADDR_W'(NEURON_NUM + 1) + ADDR_W'(term)
    : ADDR_W'(nidx) * ADDR_W'(INPUT_NUM + 1) + ADDR_W'(term);

  // The configuration writer owns the memory port only while idle.
  assign wr_ready = (state == IDLE) && arstb;
  assign wr_ok    = wr_req && wr_ready;
  assign mem_we   = wr_ok && ({1'b0, wr_addr} < DEPTH_V);
  assign mem_re   = issuing;
  assign mem_addr = (state == IDLE) ? wr_addr : issue_addr;
  assign busy     = issuing || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!arstb) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      drain_cnt  <= 1'b0;
      wr_err     <= 1'b0;
      mac_en     <= 1'b0;
      mac_clr    <= 1'b0;
      src_sel    <= 1'b0;
      src_idx    <= '0;
      bias_term  <= 1'b0;
      d1_last    <= 1'b0;
      d1_layer   <= 1'b0;
      d1_idx     <= '0;
      res_we     <= 1'b0;
      res_layer  <= 1'b0;
      res_idx    <= '0;
    end else begin
      wr_err    <= wr_ok && !mem_we;

      // Stage 1 lines up with read data; stage 2 with the updated accumulator.
      mac_en    <= issuing;
      mac_clr   <= issuing && first;
      src_sel   <= in_l2;
      src_idx   <= term[IDX_W-1:0];
      bias_term <= issuing && last_term;
      d1_last   <= issuing && last_term;
      d1_layer  <= in_l2;
      d1_idx    <= nidx;
      res_we    <= d1_last;
      res_layer <= d1_layer;
      res_idx   <= d1_idx;

      case (state)
        IDLE: begin
          if (wr_req) begin
            if (start) start_pend <= 1'b1;
          end else if (start || start_pend) begin
            state      <= L1;
            start_pend <= 1'b0;
          end
        end
        L1: begin
          if (last_all) state <= L2;
        end
        L2: begin
          if (last_all) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else drain_cnt <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// tb/tb_mlp_seq_ctrl.sv - self-checking bench for mlp_seq_ctrl against a per-cycle reference trace
module tb_mlp_seq_ctrl;

  localparam int NI = 5;
  localparam int NN = 8;
  localparam int NO = 4;
  localparam int L2B = NN * (NI + 1);
  localparam int DEPTH = L2B + NO * (NN + 1);
  localparam int END_CYC = 88;

  logic       clk = 1'b0;
  logic       arstb;
  logic       start;
  logic       wr_req;
  logic [6:0] wr_addr;
  logic       wr_ready, wr_err, mem_re, mem_we;
  logic [6:0] mem_addr;
  logic       mac_en, mac_clr, src_sel, bias_term, res_we, res_layer, busy, done;
  logic [2:0] src_idx, res_idx;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_rwe, cnt_done;

  int e_re[0:95], e_addr[0:95], e_en[0:95], e_clr[0:95], e_sel[0:95];
  int e_sidx[0:95], e_bias[0:95], e_rwe[0:95], e_rl[0:95], e_ri[0:95];

  mlp_seq_ctrl dut (
    .clk       (clk),
    .arstb     (arstb),
    .start     (start),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_ready  (wr_ready),
    .wr_err    (wr_err),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mac_en    (mac_en),
    .mac_clr   (mac_clr),
    .src_sel   (src_sel),
    .src_idx   (src_idx),
    .bias_term (bias_term),
    .res_we    (res_we),
    .res_layer (res_layer),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic w, input logic [6:0] a);
    start = s;
    wr_req = w;
    wr_addr = a;
  endtask

  task automatic check_cycle(input int c);
    chk($sformatf("busy@%0d", c), busy, (c >= 1 && c <= 86));
    chk($sformatf("done@%0d", c), done, (c == 87));
    chk($sformatf("wr_ready@%0d", c), wr_ready, (c >= 88));
    chk($sformatf("mem_we@%0d", c), mem_we, 0);
    chk($sformatf("mem_re@%0d", c), mem_re, e_re[c]);
    if (e_re[c] != 0) chk($sformatf("mem_addr@%0d", c), mem_addr, e_addr[c]);
    chk($sformatf("mac_en@%0d", c), mac_en, e_en[c]);
    if (e_en[c] != 0) begin
      chk($sformatf("mac_clr@%0d", c), mac_clr, e_clr[c]);
      chk($sformatf("src_sel@%0d", c), src_sel, e_sel[c]);
      chk($sformatf("bias_term@%0d", c), bias_term, e_bias[c]);
      if (e_bias[c] == 0) chk($sformatf("src_idx@%0d", c), src_idx, e_sidx[c]);
    end
    chk($sformatf("res_we@%0d", c), res_we, e_rwe[c]);
    if (e_rwe[c] != 0) begin
      chk($sformatf("res_layer@%0d", c), res_layer, e_rl[c]);
      chk($sformatf("res_idx@%0d", c), res_idx, e_ri[c]);
    end
    if (res_we === 1'b1) cnt_rwe++;
    if (done === 1'b1) cnt_done++;
  endtask

  // Cycle 0 is the IDLE cycle whose closing edge launches L1.
  task automatic follow(input int upto, input bit noise);
    for (int c = 1; c <= upto; c++) begin
      @(negedge clk);
      if (noise && c < END_CYC)
        drive((c == 40) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              7'($urandom_range(0, 127)));
      else
        drive(1'b0, 1'b0, 7'd0);
      #1;
      check_cycle(c);
    end
  endtask

  initial begin
    int layer, n, k, fan, t, cyc, a;
    int addrs[6];

    for (int i = 0; i < 96; i++) begin
      e_re[i] = 0; e_addr[i] = 0; e_en[i] = 0; e_clr[i] = 0; e_sel[i] = 0;
      e_sidx[i] = 0; e_bias[i] = 0; e_rwe[i] = 0; e_rl[i] = 0; e_ri[i] = 0;
    end
    for (t = 0; t < DEPTH; t++) begin
      layer = (t >= L2B) ? 1 : 0;
      fan   = layer ? NN : NI;
      n     = layer ? (t - L2B) / (NN + 1) : t / (NI + 1);
      k     = layer ? (t - L2B) % (NN + 1) : t % (NI + 1);
      cyc   = t + 1;
      e_re[cyc]       = 1;
      e_addr[cyc]     = layer ? L2B + n * (NN + 1) + k : n * (NI + 1) + k;
      e_en[cyc + 1]   = 1;
      e_clr[cyc + 1]  = (k == 0);
      e_sel[cyc + 1]  = layer;
      e_sidx[cyc + 1] = k;
      e_bias[cyc + 1] = (k == fan);
      if (k == fan) begin
        e_rwe[cyc + 2] = 1;
        e_rl[cyc + 2]  = layer;
        e_ri[cyc + 2]  = n;
      end
    end

    // Reset
    arstb = 1'b0;
    drive(1'b0, 1'b0, 7'd0);
    @(negedge clk); #1;
    chk("rst_wr_ready", wr_ready, 0);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_we", res_we, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_mem_re", mem_re, 0);
    @(negedge clk);
    arstb = 1'b1;
    #1;
    chk("post_rst_wr_ready", wr_ready, 1);

    // Config writes, including the last valid and first invalid address
    addrs[0] = 83; addrs[1] = 84; addrs[2] = 0;
    addrs[3] = 127; addrs[4] = $urandom_range(0, 83); addrs[5] = $urandom_range(84, 127);
    for (int i = 0; i < 6; i++) begin
      a = addrs[i];
      @(negedge clk);
      drive(1'b0, 1'b1, 7'(a));
      #1;
      chk($sformatf("cfg_mem_we_a%0d", a), mem_we, (a < DEPTH));
      chk($sformatf("cfg_mem_addr_a%0d", a), mem_addr, a);
      @(negedge clk);
      drive(1'b0, 1'b0, 7'd0);
      #1;
      chk($sformatf("cfg_wr_err_a%0d", a), wr_err, (a >= DEPTH));
      chk("cfg_busy", busy, 0);
    end

    // Full inference with random write/start noise while busy
    cnt_rwe = 0; cnt_done = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 7'd0);
    #1;
    chk("run1_c0_idle", busy, 0);
    follow(END_CYC, 1'b1);
    chk("run1_res_we_count", cnt_rwe, 12);
    chk("run1_done_count", cnt_done, 1);

    // start held together with writes for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 7'($urandom_range(0, 83)));
      #1;
      chk($sformatf("pend_mem_we_%0d", i), mem_we, 1);
      chk($sformatf("pend_busy_%0d", i), busy, 0);
    end
    cnt_rwe = 0; cnt_done = 0;
    @(negedge clk);
    drive(1'b0, 1'b0, 7'd0);
    #1;
    chk("pend_c0_mem_re", mem_re, 0);
    chk("pend_c0_wr_ready", wr_ready, 1);
    follow(END_CYC, 1'b0);
    chk("run2_res_we_count", cnt_rwe, 12);
    chk("run2_done_count", cnt_done, 1);

    // Reset during cycle 30, then a clean rerun
    @(negedge clk);
    drive(1'b1, 1'b0, 7'd0);
    #1;
    follow(29, 1'b1);
    @(negedge clk);
    arstb = 1'b0;
    drive(1'b0, 1'b0, 7'd0);
    #1;
    chk("abort_wr_ready_low", wr_ready, 0);
    @(negedge clk);
    arstb = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem_re", mem_re, 0);
    chk("abort_mac_en", mac_en, 0);
    chk("abort_mac_clr", mac_clr, 0);
    chk("abort_bias_term", bias_term, 0);
    chk("abort_res_we", res_we, 0);
    chk("abort_done", done, 0);
    chk("abort_wr_ready", wr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("abort_quiet_res_we_%0d", i), res_we, 0);
      chk($sformatf("abort_quiet_busy_%0d", i), busy, 0);
      chk($sformatf("abort_quiet_done_%0d", i), done, 0);
    end
    cnt_rwe = 0; cnt_done = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 7'd0);
    #1;
    follow(END_CYC, 1'b0);
    chk("run3_res_we_count", cnt_rwe, 12);
    chk("run3_done_count", cnt_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
